// File: rtl/phase_pkg.sv
// Shared definitions for Johnson-counter phase sequencing: mode encodings,
// sequencer states and helpers that map between phase index and ring code.
package phase_pkg;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    typedef enum logic [0:0] {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    // Legal ring code for phase k of an n-stage Johnson counter (n <= 31).
    function automatic logic [31:0] phase_code(input logic [31:0] n, input logic [31:0] k);
        logic [31:0] all_s;
        all_s = (32'd1 << n) - 32'd1;
        if (k < n) begin
            phase_code = (32'd1 << k) - 32'd1;
        end else begin
            phase_code = all_s & ~((32'd1 << (k - n)) - 32'd1);
        end
    endfunction

    // Phase index of a legal code: the set-bit count, mirrored for the falling half.
    function automatic logic [31:0] code_to_idx(input logic [31:0] n, input logic [31:0] code);
        logic [31:0] ones_s;
        ones_s = 32'd0;
        for (int i = 0; i < 32; i++) begin
            ones_s = ones_s + {31'd0, code[i]};
        end
        if (code[0] == 1'b1) begin
            code_to_idx = ones_s;
        end else if (ones_s == 32'd0) begin
            code_to_idx = 32'd0;
        end else begin
            code_to_idx = (32'd2 * n) - ones_s;
        end
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of a Johnson ring into one-hot phase, phase index and a
// legality flag. Illegal codes decode to all-zero phase and index 0.
module johnson_decode
    import phase_pkg::*;
#(
    parameter  int STAGES = 3,
    localparam int PW     = $clog2(2 * STAGES)
) (
    input  logic [STAGES-1:0]   state,
    output logic [2*STAGES-1:0] phase_oh,
    output logic [PW-1:0]       phase_idx,
    output logic                legal
);

    logic [2*STAGES-1:0] raw_s;

    // Legality match against every code, then adjacent-pair phase decode.
    always_comb begin
        legal = 1'b0;
        for (int k = 0; k < 2 * STAGES; k++) begin
            legal = legal | ({{(32-STAGES){1'b0}}, state} == phase_code(32'(STAGES), 32'(k)));
        end

        raw_s = {(2*STAGES){1'b0}};
        raw_s[0]      = ~state[0] & ~state[STAGES-1];
        raw_s[STAGES] =  state[0] &  state[STAGES-1];
        for (int k = 1; k < STAGES; k++) begin
            raw_s[k]          =  state[k-1] & ~state[k];
            raw_s[STAGES + k] = ~state[k-1] &  state[k];
        end

        if (legal) begin
            phase_oh  = raw_s;
            phase_idx = PW'(code_to_idx(32'(STAGES), {{(32-STAGES){1'b0}}, state}));
        end else begin
            phase_oh  = {(2*STAGES){1'b0}};
            phase_idx = {PW{1'b0}};
        end
    end

endmodule

// File: rtl/johnson_phase_seq.sv
// N-stage Johnson phase sequencer with run/hold, one-shot cycles, one-clock
// illegal-state recovery with a sticky error flag, wrap pulse and split strobes.
module johnson_phase_seq
    import phase_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int STB_PHASE = 0,
    parameter int PW        = $clog2(2 * STAGES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic                start,
    input  logic                qual,
    input  logic                err_clr,
    output logic [STAGES-1:0]   state,
    output logic [2*STAGES-1:0] phase_oh,
    output logic [PW-1:0]       phase_idx,
    output logic                wrap,
    output logic                busy,
    output logic                stb_hi,
    output logic                stb_lo,
    output logic                err
);

    logic [STAGES-1:0] state_r;
    logic              wrap_r;
    logic              err_r;
    seq_state_e        seq_r;

    logic              legal_s;
    logic              busy_s;
    logic              advance_s;
    logic              at_last_s;
    logic [STAGES-1:0] next_state_s;

    johnson_decode #(.STAGES(STAGES)) u_decode (
        .state     (state_r),
        .phase_oh  (phase_oh),
        .phase_idx (phase_idx),
        .legal     (legal_s)
    );

    assign busy_s = (seq_r == SEQ_RUN);

    // Advance qualification; a one-shot aborted by a mode switch holds for that edge.
    always_comb begin
        next_state_s = {state_r[STAGES-2:0], ~state_r[STAGES-1]};
        at_last_s    = legal_s & (phase_idx == PW'(2 * STAGES - 1));
        if (mode == MODE_FREE) begin
            advance_s = en & ~busy_s;
        end else begin
            advance_s = busy_s;
        end
    end

    // Ring register, wrap pulse, one-shot sequencer and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= {STAGES{1'b0}};
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
            seq_r   <= SEQ_IDLE;
        end else if (!legal_s) begin
            state_r <= {STAGES{1'b0}};
            wrap_r  <= 1'b0;
            err_r   <= 1'b1;
            seq_r   <= SEQ_IDLE;
        end else begin
            err_r <= err_r & ~err_clr;
            if (advance_s) begin
                state_r <= next_state_s;
                wrap_r  <= at_last_s;
            end else begin
                state_r <= state_r;
                wrap_r  <= 1'b0;
            end
            case (seq_r)
                SEQ_IDLE: begin
                    if ((mode == MODE_ONESHOT) && start) begin
                        seq_r <= SEQ_RUN;
                    end else begin
                        seq_r <= SEQ_IDLE;
                    end
                end
                SEQ_RUN: begin
                    if ((mode != MODE_ONESHOT) || at_last_s) begin
                        seq_r <= SEQ_IDLE;
                    end else begin
                        seq_r <= SEQ_RUN;
                    end
                end
                default: seq_r <= SEQ_IDLE;
            endcase
        end
    end

    assign state  = state_r;
    assign wrap   = wrap_r;
    assign busy   = busy_s;
    assign err    = err_r;
    assign stb_hi = phase_oh[STB_PHASE] &  qual;
    assign stb_lo = phase_oh[STB_PHASE] & ~qual;

endmodule

// File: tb/tb_johnson_phase_seq.sv
// Directed self-checking bench: a 3-stage instance (strobe phase 2) and a
// 5-stage instance exercised with hand-computed expected sequences.
module tb_johnson_phase_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, mode, start, qual, err_clr;
    logic [2:0] state;
    logic [5:0] phase_oh;
    logic [2:0] phase_idx;
    logic       wrap, busy, stb_hi, stb_lo, err;

    logic       rst_n5, en5, mode5, start5, qual5, err_clr5;
    logic [4:0] state5;
    logic [9:0] oh5;
    logic [3:0] idx5;
    logic       wrap5, busy5, hi5, lo5, err5;

    int checks   = 0;
    int failures = 0;
    int ph;

    logic [2:0] seq3 [6]  = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
    logic [4:0] seq5 [10] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                              5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};

    johnson_phase_seq #(.STAGES(3), .STB_PHASE(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start), .qual(qual),
        .err_clr(err_clr), .state(state), .phase_oh(phase_oh), .phase_idx(phase_idx),
        .wrap(wrap), .busy(busy), .stb_hi(stb_hi), .stb_lo(stb_lo), .err(err)
    );

    johnson_phase_seq #(.STAGES(5)) dut5 (
        .clk(clk), .rst_n(rst_n5), .en(en5), .mode(mode5), .start(start5), .qual(qual5),
        .err_clr(err_clr5), .state(state5), .phase_oh(oh5), .phase_idx(idx5),
        .wrap(wrap5), .busy(busy5), .stb_hi(hi5), .stb_lo(lo5), .err(err5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0; qual = 1'b0; err_clr = 1'b0;
        rst_n5 = 1'b0; en5 = 1'b0; mode5 = 1'b0; start5 = 1'b0; qual5 = 1'b0; err_clr5 = 1'b0;
        repeat (2) tick();

        chk("rst_state", 32'(state), 32'd0);
        chk("rst_oh", 32'(phase_oh), 32'h01);
        chk("rst_idx", 32'(phase_idx), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stb", 32'({stb_hi, stb_lo}), 32'd0);

        // Free-run, two full cycles
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("fr_state", 32'(state), 32'(seq3[i % 6]));
            chk("fr_idx", 32'(phase_idx), 32'((i + 1) % 6));
            chk("fr_wrap", 32'(wrap), 32'(i % 6 == 5));
        end

        // Hold at phase 3
        repeat (3) tick();
        chk("pre_hold_state", 32'(state), 32'b111);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_state", 32'(state), 32'b111);
            chk("hold_oh", 32'(phase_oh), 32'b001000);
            chk("hold_wrap", 32'(wrap), 32'd0);
        end

        // Qualified strobes at phase 2, qual toggling each cycle
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            qual = i[0];
            tick();
            ph = (4 + i) % 6;
            chk("stb_hi", 32'(stb_hi), 32'((ph == 2) && qual));
            chk("stb_lo", 32'(stb_lo), 32'((ph == 2) && !qual));
            if (ph == 2) begin
                qual = ~qual;
                #1;
                chk("stb_hi_flip", 32'(stb_hi), 32'(qual));
                chk("stb_lo_flip", 32'(stb_lo), 32'(!qual));
            end
        end
        chk("stb_end_state", 32'(state), 32'd0);

        // One-shot: idle hold, arm, traverse, ignored restart
        mode = 1'b1;
        tick();
        chk("os_idle_state", 32'(state), 32'd0);
        chk("os_idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("os_arm_busy", 32'(busy), 32'd1);
        chk("os_arm_state", 32'(state), 32'd0);
        chk("os_arm_wrap", 32'(wrap), 32'd0);
        for (int i = 0; i < 6; i++) begin
            start = (i == 2);
            tick();
            chk("os_state", 32'(state), 32'(seq3[i]));
            chk("os_busy", 32'(busy), 32'(i < 5));
            chk("os_wrap", 32'(wrap), 32'(i == 5));
        end
        start = 1'b0;
        tick();
        chk("os_done_state", 32'(state), 32'd0);
        chk("os_done_busy", 32'(busy), 32'd0);
        chk("os_done_wrap", 32'(wrap), 32'd0);

        // Mode switch mid-cycle aborts and holds
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ms_state", 32'(state), 32'b011);
        mode = 1'b0;
        tick();
        chk("ms_busy", 32'(busy), 32'd0);
        chk("ms_hold", 32'(state), 32'b011);
        tick();
        chk("ms_free_state", 32'(state), 32'b111);

        // Illegal 010 with hold, then err_clr
        en = 1'b0;
        force dut3.state_r = 3'b010;
        #1;
        chk("ill_state", 32'(state), 32'b010);
        chk("ill_oh", 32'(phase_oh), 32'd0);
        chk("ill_idx", 32'(phase_idx), 32'd0);
        release dut3.state_r;
        tick();
        chk("rec_state", 32'(state), 32'd0);
        chk("rec_err", 32'(err), 32'd1);
        chk("rec_wrap", 32'(wrap), 32'd0);
        chk("rec_oh", 32'(phase_oh), 32'h01);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_err", 32'(err), 32'd0);

        // Illegal 101 while enabled, then set beats clear
        en = 1'b1;
        force dut3.state_r = 3'b101;
        #1;
        chk("ill2_oh", 32'(phase_oh), 32'd0);
        release dut3.state_r;
        tick();
        chk("rec2_state", 32'(state), 32'd0);
        chk("rec2_err", 32'(err), 32'd1);
        err_clr = 1'b1;
        force dut3.state_r = 3'b010;
        #1;
        release dut3.state_r;
        tick();
        chk("setwins_err", 32'(err), 32'd1);
        chk("setwins_state", 32'(state), 32'd0);
        tick();
        err_clr = 1'b0;
        chk("clr2_err", 32'(err), 32'd0);
        chk("clr2_state", 32'(state), 32'b001);

        // Five-stage ring: full cycle of ten codes
        rst_n5 = 1'b1; en5 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s5_state", 32'(state5), 32'(seq5[i]));
            chk("s5_idx", 32'(idx5), 32'((i + 1) % 10));
            chk("s5_oh", 32'(oh5), 32'd1 << ((i + 1) % 10));
            chk("s5_wrap", 32'(wrap5), 32'(i == 9));
        end

        // Set err, arm a one-shot, then reset mid-cycle
        en5 = 1'b0;
        force dut5.state_r = 5'b01010;
        #1;
        chk("s5_ill_oh", 32'(oh5), 32'd0);
        release dut5.state_r;
        tick();
        chk("s5_err", 32'(err5), 32'd1);
        mode5 = 1'b1; start5 = 1'b1;
        tick();
        start5 = 1'b0;
        chk("s5_busy", 32'(busy5), 32'd1);
        tick();
        tick();
        chk("s5_os_state", 32'(state5), 32'b00011);
        #2;
        rst_n5 = 1'b0;
        #1;
        chk("s5_rst_state", 32'(state5), 32'd0);
        chk("s5_rst_busy", 32'(busy5), 32'd0);
        chk("s5_rst_err", 32'(err5), 32'd0);
        chk("s5_rst_wrap", 32'(wrap5), 32'd0);
        chk("s5_rst_idx", 32'(idx5), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/johnson_phase_seq.md
Name: johnson_phase_seq

Overview:
- Parametrised successor to the fixed 3-flop digit/phase shifter in the MC14433 model.
- An N-stage twisted-ring (Johnson) counter generates 2N non-overlapping one-hot phase strobes for digit scanning and conversion-phase sequencing.
- Added over the fixed-width version: width parameter, run/hold, one-shot mode, illegal-state recovery with a sticky error flag, an encoded phase index, a wrap pulse, and qualifier-split strobes.

Parameters:
- STAGES, 3, number of Johnson flops; must be ≥2; the sequence has 2*STAGES phases.
- STB_PHASE, 0, phase index at which qualified strobes stb_hi/stb_lo fire; range 0..2*STAGES-1.
- PW, $clog2(2*STAGES), width of the phase index (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; state holds when low (free-run mode).
- mode  in  1  0 = free-run, 1 = one-shot.
- start  in  1  one-shot trigger; ignored in free-run mode.
- qual  in  1  external qualifier (e.g. Q8 polarity).
- err_clr  in  1  clears sticky err.
- state  out  STAGES  raw Johnson register.
- phase_oh  out  2*STAGES  one-hot decoded phase.
- phase_idx  out  PW  encoded phase, 0..2*STAGES-1.
- wrap  out  1  one-cycle pulse on the step from phase 2*STAGES-1 to phase 0.
- busy  out  1  one-shot cycle in progress.
- stb_hi  out  1  phase_oh[STB_PHASE] & qual.
- stb_lo  out  1  phase_oh[STB_PHASE] & ~qual.
- err  out  1  sticky illegal-state flag.

Behaviour:
- Reset (async, rst_n low): state=0, wrap=0, busy=0, err=0. Consequently phase_oh=1, phase_idx=0, and the strobes follow qual.
- Step rule: state <= {state[STAGES-2:0], ~state[STAGES-1]}.
- Sequence for STAGES=3: 000 → 001 → 011 → 111 → 110 → 100 → 000.
- Phase k:
  - k < STAGES: the low k bits are set.
  - k ≥ STAGES: the low k-STAGES bits are clear and the rest are set.
- Decode:
  - phase_oh and phase_idx are combinational from the registered state.
  - Each phase_oh bit uses an adjacent-pair two-bit decode (bits 0 and STAGES-1 for the end phases), so at most one bit is high for legal states.
  - stb_hi and stb_lo are combinational; they are never both high.
- Advance condition:
  - Free-run: advance when en=1.
  - One-shot: advance when busy=1; en is ignored.
- One-shot protocol:
  - start=1 while busy=0 sets busy on the next edge; the state does not move that cycle.
  - The counter then advances for 2*STAGES clocks.
  - busy clears on the same edge that returns state to phase 0 and fires wrap.
  - start while busy=1 is ignored (no restart, no queueing).
  - Switching mode mid-cycle clears busy at the next edge and holds the current phase.
- wrap is registered: high for exactly the cycle after the phase 2*STAGES-1 → 0 step.
- Illegal states (any value not among the 2*STAGES legal codes, e.g. 010 or 101 for N=3):
  - Checked every clock regardless of en.
  - Next state is forced to 0 and err is set; wrap does not fire.
  - busy clears.
  - phase_oh=0 and phase_idx=0 while the state is illegal.
  - Recovery takes 1 clock, versus the multi-cycle self-correction of the fixed version.
- err:
  - Cleared by err_clr=1 at the clock edge.
  - If err_clr and a new illegal detection coincide, set wins.
- Reset mid-cycle: immediate return to the reset values; no partial wrap.

Decomposition:
- Shared package (phase_pkg): helper function for legal-code generation, phase-code-to-index function, and mode encodings MODE_FREE=0 / MODE_ONESHOT=1.
- One natural sub-module: johnson_decode (combinational state → phase_oh/phase_idx/legal), parametrised by STAGES and reused by display-scan blocks.
- The sequencing FSM (idle/run for one-shot), error logic and strobes live in the top module.

Test Plan:
- Reset, then free-run with STAGES=3, en=1, 12 clocks:
  - state follows 000,001,011,111,110,100 twice.
  - phase_idx follows 0..5.
  - wrap is high exactly at cycles 6 and 12.
- en toggled low for 3 clocks at phase 3: state holds 111, phase_oh=000111_onehot bit3, and no wrap.
- One-shot mode=1, pulse start:
  - busy=1 for 6 clocks after the arm edge; the state traverses all 6 phases and ends at 000.
  - wrap pulses once; busy=0 is coincident with the return to phase 0.
  - A second start mid-run is ignored.
- Force state=010 via the bench: the next edge gives state=000 and err=1; phase_oh=0 while illegal; err_clr → err=0. Repeat with 101.
- STB_PHASE=2, qual toggled each cycle during free-run: stb_hi/stb_lo fire only in phase 2, with exactly one of them high, matching qual.
- STAGES=5 (10 phases): full-cycle check of all 10 codes, phase_idx 0..9, and a single wrap per 10 clocks; assert rst_n low mid-sequence → immediate state=0, busy=0, err=0.
